// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame FSM states, scan-code prefixes, data width.
// Used by the receive controller; prefix constants only matter with PS2_CODE_DECODE_EN.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam int         PS2_DATA_BITS    = 8;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_fall_det.sv
// Falling-edge detector: registers the line and pulses fall for one cycle on a 1->0 step.
// Zero latency (pulse in the cycle the low level first appears); no backpressure.
module ps2_fall_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic fall
);

  logic prev;

  // Idle PS/2 lines sit high, so a reset of 1 avoids a false edge after reset.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= sig;
  end

  assign fall = prev & ~sig;

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive frame controller; byte valid one cycle after the stop-bit fall, single holding register,
// new byte dropped (overrun pulse) while the consumer stalls. PS2_CODE_DECODE_EN folds E0/F0 prefixes into flags.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_db,
  input  logic       ps2_data_db,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_ext,
  output logic       out_break,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overrun
);

  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  logic                     fall;
  ps2_state_e               state;
  logic [2:0]               idx;
  logic [7:0]               shreg;
  logic                     par_bit;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic                     tmo_hit;
  logic                     stop_evt;
  logic                     par_ok;
  logic                     deliver;
  logic                     blocked;
  logic                     is_prefix;

  ps2_fall_det u_fall_det (
    .clk  (clk),
    .rst  (rst),
    .sig  (ps2_clk_db),
    .fall (fall)
  );

  // Abort when the counter would step into all-ones with no edge in sight.
  assign tmo_hit  = (state != ST_IDLE) && !fall && (tmo_cnt == TMO_LAST);
  assign stop_evt = fall && (state == ST_STOP);
  assign par_ok   = ps2_parity_ok(shreg, par_bit);
  assign deliver  = stop_evt && par_ok && ps2_data_db;
  assign blocked  = out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= 3'd0;
      shreg   <= 8'd0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (state == ST_IDLE || fall || tmo_hit) tmo_cnt <= '0;
      else                                     tmo_cnt <= tmo_cnt + TMO_ONE;

      if (tmo_hit) begin
        state <= ST_IDLE;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!ps2_data_db) begin
              state <= ST_DATA;
              idx   <= 3'd0;
            end
          end
          ST_DATA: begin
            shreg[idx] <= ps2_data_db;
            idx        <= idx + 3'd1;
            if (idx == 3'(PS2_DATA_BITS - 1)) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= ps2_data_db;
            state   <= ST_STOP;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef PS2_CODE_DECODE_EN
  logic ext_pend;
  logic brk_pend;

  assign is_prefix = (shreg == PS2_PREFIX_EXT) || (shreg == PS2_PREFIX_BREAK);

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if ((stop_evt && !deliver) || tmo_hit || (deliver && blocked)) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (deliver) begin
      if (shreg == PS2_PREFIX_EXT)        ext_pend <= 1'b1;
      else if (shreg == PS2_PREFIX_BREAK) brk_pend <= 1'b1;
      else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ext   <= 1'b0;
      out_break <= 1'b0;
    end else if (deliver && !blocked && !is_prefix) begin
      out_ext   <= ext_pend;
      out_break <= brk_pend;
    end
  end
`else
  assign is_prefix = 1'b0;
  assign out_ext   = 1'b0;
  assign out_break = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= 8'd0;
      out_valid  <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Parity failure masks a bad stop bit in the same frame.
      err_parity <= stop_evt && !par_ok;
      err_frame  <= (stop_evt && par_ok && !ps2_data_db) || tmo_hit;
      overrun    <= deliver && blocked;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (deliver && !blocked && !is_prefix) begin
        out_data  <= shreg;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl: directed frames plus random frames against a frame-level model.
module tb_ps2_rx_ctrl;

  localparam int TW   = 8;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_db = 1'b1;
  logic       ps2_data_db = 1'b1;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid, out_ext, out_break, err_parity, err_frame, overrun;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_rx_ctrl #(.TIMEOUT_WIDTH(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_db  (ps2_clk_db),
    .ps2_data_db (ps2_data_db),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ext     (out_ext),
    .out_break   (out_break),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .overrun     (overrun)
  );

  // Observed activity, sampled on the falling clk edge.
  int          got_perr = 0, got_ferr = 0, got_ovr = 0;
  int unsigned vrise_cyc = 0, ferr_cyc = 0;
  logic        v_q = 1'b0;
  logic [9:0]  got_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (err_parity) got_perr++;
      if (err_frame) begin
        got_ferr++;
        ferr_cyc = cyc;
      end
      if (overrun) got_ovr++;
      if (out_valid && !v_q) vrise_cyc = cyc;
      if (out_valid && out_ready) got_q.push_back({out_break, out_ext, out_data});
    end
    v_q = out_valid;
  end

  // Frame-level reference model.
  logic [9:0] exp_q[$];
  int         exp_perr = 0, exp_ferr = 0, exp_ovr = 0;
  logic       m_hold = 1'b0, m_ext = 1'b0, m_brk = 1'b0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic v);
    out_ready = v;
    if (v) m_hold = 1'b0;
  endtask

  task automatic drive_bit(input logic b, output int unsigned fall_cyc);
    ps2_data_db = b;
    tick(HALF);
    ps2_clk_db = 1'b0;
    fall_cyc   = cyc + 1;
    tick(HALF);
    ps2_clk_db = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic par_ok, input logic stop_ok,
                             output logic loaded);
    loaded = 1'b0;
    if (!par_ok) begin
      exp_perr++;
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (!stop_ok) begin
      exp_ferr++;
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (m_hold && !out_ready) begin
      exp_ovr++;
      m_ext = 1'b0; m_brk = 1'b0;
`ifdef PS2_CODE_DECODE_EN
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
`endif
    end else begin
      exp_q.push_back({m_brk, m_ext, b});
      m_hold = !out_ready;
      m_ext  = 1'b0; m_brk = 1'b0;
      loaded = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_v);
    logic [10:0] bits;
    int unsigned fc;
    logic        loaded;
    bits = {stop_v, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) drive_bit(bits[i], fc);
    model_frame(b, !bad_par, stop_v, loaded);
    if (loaded) check("valid_latency", vrise_cyc, fc);
  endtask

  // Start bit plus n data bits, then the line goes quiet.
  task automatic send_partial(input logic [7:0] b, input int n, output int unsigned fc);
    drive_bit(1'b0, fc);
    for (int i = 0; i < n; i++) drive_bit(b[i], fc);
  endtask

  task automatic sync(input string tag);
    int n_acc;
    tick(4);
    check({tag, "_perr"}, got_perr, exp_perr);
    check({tag, "_ferr"}, got_ferr, exp_ferr);
    check({tag, "_ovr"},  got_ovr,  exp_ovr);
    n_acc = exp_q.size() - int'(m_hold);
    check({tag, "_nacc"}, got_q.size(), n_acc);
    while (got_q.size() > 0 && n_acc > 0) begin
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
      n_acc--;
    end
    got_q.delete();
    while (exp_q.size() > int'(m_hold)) void'(exp_q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  out_data,   0);
    check({tag, "_valid"}, out_valid,  0);
    check({tag, "_ext"},   out_ext,    0);
    check({tag, "_brk"},   out_break,  0);
    check({tag, "_perr"},  err_parity, 0);
    check({tag, "_ferr"},  err_frame,  0);
    check({tag, "_ovr"},   overrun,    0);
  endtask

  initial begin
    int unsigned fc;
    logic [7:0]  rb;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(5);

    set_ready(1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    sync("good_1c");

    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    sync("parity");

    send_frame(8'h1C, 1'b0, 1'b0);
    sync("stop0");

    send_partial(8'h1C, 4, fc);
    tick(255 - HALF + 10);
    exp_ferr++;
    m_ext = 1'b0; m_brk = 1'b0;
    check("timeout_cycle", ferr_cyc, fc + 255);
    send_frame(8'h1C, 1'b0, 1'b1);
    sync("timeout");

    set_ready(1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    check("ovr_hold_data", out_data, 8'h1C);
    check("ovr_hold_valid", out_valid, 1);
    set_ready(1'b1);
    tick(1);
    check("ready_drop", out_valid, 0);
    sync("overrun");

    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    sync("prefix");

    // Reset mid-frame with a byte still parked in the holding register.
    set_ready(1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    send_partial(8'hFF, 5, fc);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("midreset");
    rst = 1'b0;
    if (m_hold) void'(exp_q.pop_back());
    m_hold = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
    set_ready(1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    sync("after_reset");

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) set_ready(1'b0);
      else                           set_ready(1'b1);
      case ($urandom_range(0, 4))
        0:       rb = 8'hE0;
        1:       rb = 8'hF0;
        default: rb = 8'($urandom);
      endcase
      send_frame(rb, $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0);
    end
    set_ready(1'b1);
    sync("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
